// File: rtl/magnitude_comparator_seq.sv
// Multi-cycle magnitude comparator: walks the operands MSB-first, DIGIT bits per
// cycle, and stops at the first differing digit with a one-hot gt/eq/lt result.
module magnitude_comparator_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("magnitude_comparator_seq: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    COMPARE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;

  // The operands shift left each cycle, so the digit under test always sits at the top.
  assign dig_a = a_q[WIDTH-1 -: DIGIT];
  assign dig_b = b_q[WIDTH-1 -: DIGIT];

  // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= signed_mode ? (a ^ SIGN_MASK) : a;
            b_q   <= signed_mode ? (b ^ SIGN_MASK) : b;
            cnt   <= CW'(NDIG - 1);
            busy  <= 1'b1;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          if (dig_a != dig_b) begin
            gt    <= (dig_a > dig_b);
            lt    <= (dig_a < dig_b);
            eq    <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == '0) begin
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            a_q <= a_q << DIGIT;
            b_q <= b_q << DIGIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_magnitude_comparator_seq.sv
// Directed bench for magnitude_comparator_seq: default 8/2 instance for handshake
// scenarios, plus 8/8 and 6/1 instances exercised against a reference compare.
module tb_magnitude_comparator_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start, signed_mode, busy, done, gt, eq, lt;
  logic [7:0] a, b;

  logic       d8_start, d8_signed, d8_busy, d8_done, d8_gt, d8_eq, d8_lt;
  logic [7:0] d8_a, d8_b;

  logic       d1_start, d1_signed, d1_busy, d1_done, d1_gt, d1_eq, d1_lt;
  logic [5:0] d1_a, d1_b;

  int checks = 0;
  int errors = 0;

  magnitude_comparator_seq #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
  );

  magnitude_comparator_seq #(.WIDTH(8), .DIGIT(8)) dut_d8 (
    .clk(clk), .rst_n(rst_n), .start(d8_start), .signed_mode(d8_signed),
    .a(d8_a), .b(d8_b), .busy(d8_busy), .done(d8_done), .gt(d8_gt), .eq(d8_eq), .lt(d8_lt)
  );

  magnitude_comparator_seq #(.WIDTH(6), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .start(d1_start), .signed_mode(d1_signed),
    .a(d1_a), .b(d1_b), .busy(d1_busy), .done(d1_done), .gt(d1_gt), .eq(d1_eq), .lt(d1_lt)
  );

  // Leaves the bench at the falling edge just after the capturing edge (edge 0).
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic sm);
    @(negedge clk);
    a = ta; b = tb_v; signed_mode = sm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    d8_start = 1'b0; d8_signed = 1'b0; d8_a = '0; d8_b = '0;
    d1_start = 1'b0; d1_signed = 1'b0; d1_a = '0; d1_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, gt, eq, lt} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_default: got %b expected 00000", {busy, done, gt, eq, lt});
    end
    checks++;
    if ({d8_busy, d8_done, d8_gt, d8_eq, d8_lt, d1_busy, d1_done, d1_gt, d1_eq, d1_lt} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_variants: got %b expected 0000000000",
               {d8_busy, d8_done, d8_gt, d8_eq, d8_lt, d1_busy, d1_done, d1_gt, d1_eq, d1_lt});
    end
    rst_n = 1'b1;
  endtask

  // Scenario runner for the default instance: checks latency, busy count and result.
  task automatic test_vector(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                             input logic sm, input int exp_lat, input logic [2:0] exp_res);
    int lat, bc;
    start_op(ta, tb_v, sm);
    wait_done(lat, bc);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("[TB] FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (bc !== exp_lat) begin
      errors++;
      $display("[TB] FAIL %s_busy_cycles: got %0d expected %0d", name, bc, exp_lat);
    end
    checks++;
    if ({gt, eq, lt} !== exp_res) begin
      errors++;
      $display("[TB] FAIL %s_result: got gt/eq/lt=%b expected %b", name, {gt, eq, lt}, exp_res);
    end
  endtask

  task automatic test_equal();
    test_vector("eq_5a", 8'h5A, 8'h5A, 1'b0, 4, 3'b010);
    @(negedge clk);
    checks++;
    if ({done, busy, gt, eq, lt} !== 5'b00010) begin
      errors++;
      $display("[TB] FAIL eq_done_pulse: got done/busy/gt/eq/lt=%b expected 00010", {done, busy, gt, eq, lt});
    end
  endtask

  task automatic test_modes();
    test_vector("uns_c0_3f", 8'hC0, 8'h3F, 1'b0, 1, 3'b100);
    test_vector("sgn_c0_3f", 8'hC0, 8'h3F, 1'b1, 1, 3'b001);
    test_vector("uns_12_13", 8'h12, 8'h13, 1'b0, 4, 3'b001);
    test_vector("sgn_ff_fe", 8'hFF, 8'hFE, 1'b1, 4, 3'b100);
  endtask

  task automatic test_handshake();
    int lat, bc;
    start_op(8'h00, 8'h01, 1'b0);
    @(negedge clk);
    a = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'h00;
    wait_done(lat, bc);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("[TB] FAIL busy_start_latency: got %0d extra edges expected 2", lat);
    end
    checks++;
    if ({gt, eq, lt} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL busy_start_result: got gt/eq/lt=%b expected 001", {gt, eq, lt});
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    start_op(8'h5A, 8'h5B, 1'b0);
    wait_done(lat, bc);
    checks++;
    if (lat !== 4 || {gt, eq, lt} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL b2b_first: got lat=%0d gt/eq/lt=%b expected lat=4 001", lat, {gt, eq, lt});
    end
    a = 8'h80; b = 8'h00; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got busy/done=%b expected 10", {busy, done});
    end
    wait_done(lat, bc);
    checks++;
    if (lat !== 1 || {gt, eq, lt} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL b2b_second: got lat=%0d gt/eq/lt=%b expected lat=1 100", lat, {gt, eq, lt});
    end
  endtask

  task automatic test_reset_midop();
    int seen_done;
    start_op(8'h01, 8'h01, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busy, done, gt, eq, lt} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL midop_reset_clear: got %b expected 00000", {busy, done, gt, eq, lt});
    end
    seen_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("[TB] FAIL midop_no_done: got %0d done pulses expected 0", seen_done);
    end
    test_vector("after_reset", 8'h02, 8'h01, 1'b0, 4, 3'b100);
  endtask

  task automatic test_digit8_random();
    logic [2:0] exp_res;
    int lat;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      d8_a = 8'($urandom_range(0, 255));
      d8_b = (i % 4 == 0) ? d8_a : 8'($urandom_range(0, 255));
      d8_signed = (i >= 8);
      d8_start = 1'b1;
      @(negedge clk);
      d8_start = 1'b0;
      if (d8_signed)
        exp_res = {$signed(d8_a) > $signed(d8_b), d8_a == d8_b, $signed(d8_a) < $signed(d8_b)};
      else
        exp_res = {d8_a > d8_b, d8_a == d8_b, d8_a < d8_b};
      lat = -1;
      if (!d8_busy) begin
        checks++; errors++;
        $display("[TB] FAIL d8_busy[%0d]: got 0 expected 1", i);
      end
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (d8_done) begin lat = k; break; end
      end
      checks++;
      if (lat !== 1 || {d8_gt, d8_eq, d8_lt} !== exp_res) begin
        errors++;
        $display("[TB] FAIL d8_rand[%0d] a=%h b=%h s=%b: got lat=%0d res=%b expected lat=1 res=%b",
                 i, d8_a, d8_b, d8_signed, lat, {d8_gt, d8_eq, d8_lt}, exp_res);
      end
    end
  endtask

  task automatic test_digit1_random();
    logic [2:0] exp_res;
    logic [5:0] diff;
    int lat, exp_lat;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      d1_a = 6'($urandom_range(0, 63));
      d1_b = (i % 4 == 1) ? d1_a : 6'($urandom_range(0, 63));
      d1_signed = (i % 2 == 1);
      d1_start = 1'b1;
      @(negedge clk);
      d1_start = 1'b0;
      if (d1_signed)
        exp_res = {$signed(d1_a) > $signed(d1_b), d1_a == d1_b, $signed(d1_a) < $signed(d1_b)};
      else
        exp_res = {d1_a > d1_b, d1_a == d1_b, d1_a < d1_b};
      diff = d1_a ^ d1_b;
      exp_lat = 6;
      for (int j = 0; j < 6; j++) begin
        if (diff[j]) exp_lat = 6 - j;
      end
      lat = -1;
      if (!d1_busy) begin
        checks++; errors++;
        $display("[TB] FAIL d1_busy[%0d]: got 0 expected 1", i);
      end
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (d1_done) begin lat = k; break; end
      end
      checks++;
      if (lat !== exp_lat || {d1_gt, d1_eq, d1_lt} !== exp_res) begin
        errors++;
        $display("[TB] FAIL d1_rand[%0d] a=%h b=%h s=%b: got lat=%0d res=%b expected lat=%0d res=%b",
                 i, d1_a, d1_b, d1_signed, lat, {d1_gt, d1_eq, d1_lt}, exp_lat, exp_res);
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_modes();
    test_handshake();
    test_back_to_back();
    test_reset_midop();
    test_digit8_random();
    test_digit1_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
